issue_dispatch: RTL and testbench

ISSUE_DISPATCH -- requirements
Module: issue_dispatch

---
 rtl/issue_dispatch.sv | 172 +++++++++++++++++
 tb/tb_issue_dispatch.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_dispatch.sv
// Issue/dispatch stage: a one-entry instruction buffer with a small FSM.
// It classifies each accepted decode word, then presents the instruction to
// the ALU, load/store or CSR channel, waits for a fence to drain, or raises
// a synchronous trap.
module issue_dispatch (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_decode,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_rs1,
   input  logic [31:0] in_rs2,
   input  logic [31:0] in_imm,
   input  logic [4:0]  in_rd,
   output logic        alu_valid,
   input  logic        alu_ready,
   output logic        ls_valid,
   input  logic        ls_ready,
   output logic        csr_valid,
   input  logic        csr_ready,
   output logic [9:0]  out_op,
   output logic [31:0] out_pc,
   output logic [31:0] out_a,
   output logic [31:0] out_b,
   output logic [31:0] out_imm,
   output logic [4:0]  out_rd,
   input  logic        ls_idle,
   input  logic        flush,
   output logic        trap_valid,
   output logic [3:0]  trap_cause,
   output logic [31:0] trap_pc,
   input  logic        trap_ack,
   output logic        fence_done
);

   typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_FENCE_WAIT, ST_TRAP} state_t;

   state_t      r_state;
   logic        r_alu_valid, r_ls_valid, r_csr_valid;
   logic        r_trap_valid;
   logic [3:0]  r_trap_cause;
   logic [31:0] r_trap_pc;
   logic [9:0]  r_op;
   logic [31:0] r_pc, r_a, r_b, r_imm;
   logic [4:0]  r_rd;

   logic        w_hs, w_accept;
   logic        w_is_trap, w_is_fence, w_to_alu, w_to_ls, w_to_csr;
   logic [3:0]  w_cause;

   assign w_hs     = (r_alu_valid & alu_ready) | (r_ls_valid & ls_ready) | (r_csr_valid & csr_ready);
   assign in_ready = ~flush & ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & w_hs));
   assign w_accept = in_valid & in_ready;

   // The pulse coincides with the cycle the load/store unit reports idle;
   // a flush in that same cycle discards the fence instead of retiring it.
   assign fence_done = (r_state == ST_FENCE_WAIT) & ls_idle & ~flush;

   assign alu_valid  = r_alu_valid;
   assign ls_valid   = r_ls_valid;
   assign csr_valid  = r_csr_valid;
   assign trap_valid = r_trap_valid;
   assign trap_cause = r_trap_cause;
   assign trap_pc    = r_trap_pc;
   assign out_op     = r_op;
   assign out_pc     = r_pc;
   assign out_a      = r_a;
   assign out_b      = r_b;
   assign out_imm    = r_imm;
   assign out_rd     = r_rd;

   // Classify the incoming decode word: illegal > ecall > ebreak > fence > csr > unit.
   always_comb begin
      w_is_trap  = 1'b0;
      w_is_fence = 1'b0;
      w_to_alu   = 1'b0;
      w_to_ls    = 1'b0;
      w_to_csr   = 1'b0;
      w_cause    = '0;
      if (in_decode[1]) begin
         w_is_trap = 1'b1;
         w_cause   = 4'd2;
      end else if (in_decode[3]) begin
         w_is_trap = 1'b1;
         w_cause   = 4'd11;
      end else if (in_decode[2]) begin
         w_is_trap = 1'b1;
         w_cause   = 4'd3;
      end else if (in_decode[4]) begin
         w_is_fence = 1'b1;
      end else if (in_decode[5]) begin
         w_to_csr = 1'b1;
      end else if (in_decode[15:14] == 2'd0) begin
         w_to_alu = 1'b1;
      end else if (in_decode[15:14] == 2'd1) begin
         w_to_ls = 1'b1;
      end else begin
         w_is_trap = 1'b1;
         w_cause   = 4'd2;
      end
   end

   // State, channel valids, trap registers and payload buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_alu_valid  <= 1'b0;
         r_ls_valid   <= 1'b0;
         r_csr_valid  <= 1'b0;
         r_trap_valid <= 1'b0;
         r_trap_cause <= '0;
         r_trap_pc    <= '0;
         r_op         <= '0;
         r_pc         <= '0;
         r_a          <= '0;
         r_b          <= '0;
         r_imm        <= '0;
         r_rd         <= '0;
      end else if (flush) begin
         r_state      <= ST_IDLE;
         r_alu_valid  <= 1'b0;
         r_ls_valid   <= 1'b0;
         r_csr_valid  <= 1'b0;
         r_trap_valid <= 1'b0;
      end else if (w_accept) begin
         // unit[1] is dropped from out_op: ALU/LS instructions always have
         // unit 0 or 1, and for CSR the channel itself identifies the target.
         r_op         <= {in_decode[14], in_decode[13:11], in_decode[10:7], in_decode[6], in_decode[0]};
         r_pc         <= in_pc;
         r_a          <= in_rs1;
         r_b          <= in_rs2;
         r_imm        <= in_imm;
         r_rd         <= in_rd;
         r_alu_valid  <= w_to_alu;
         r_ls_valid   <= w_to_ls;
         r_csr_valid  <= w_to_csr;
         r_trap_valid <= w_is_trap;
         if (w_is_trap) begin
            r_trap_cause <= w_cause;
            r_trap_pc    <= in_pc;
            r_state      <= ST_TRAP;
         end else if (w_is_fence) begin
            r_state <= ST_FENCE_WAIT;
         end else begin
            r_state <= ST_HOLD;
         end
      end else begin
         case (r_state)
            ST_HOLD: begin
               if (w_hs) begin
                  r_state     <= ST_IDLE;
                  r_alu_valid <= 1'b0;
                  r_ls_valid  <= 1'b0;
                  r_csr_valid <= 1'b0;
               end
            end
            ST_FENCE_WAIT: begin
               if (ls_idle) r_state <= ST_IDLE;
            end
            ST_TRAP: begin
               if (trap_ack) begin
                  r_state      <= ST_IDLE;
                  r_trap_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_issue_dispatch.sv
// Scoreboard bench for issue_dispatch: randomized traffic checked against a
// transaction-level model, followed by directed boundary scenarios.
module tb_issue_dispatch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [15:0] in_decode;
   logic [31:0] in_pc, in_rs1, in_rs2, in_imm;
   logic [4:0]  in_rd;
   logic        alu_valid, alu_ready, ls_valid, ls_ready, csr_valid, csr_ready;
   logic [9:0]  out_op;
   logic [31:0] out_pc, out_a, out_b, out_imm;
   logic [4:0]  out_rd;
   logic        ls_idle, flush, trap_valid, trap_ack, fence_done;
   logic [3:0]  trap_cause;
   logic [31:0] trap_pc;

   int n_pass  = 0;
   int n_total = 0;
   logic sb_en = 1'b0;

   // kind: 0 alu, 1 ls, 2 csr, 3 trap, 4 fence
   typedef struct {
      int          kind;
      logic [3:0]  cause;
      logic [9:0]  op;
      logic [31:0] pc, a, b, imm;
      logic [4:0]  rd;
   } exp_t;

   exp_t sb[$];

   issue_dispatch dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_decode(in_decode),
      .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_rd(in_rd),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .ls_valid(ls_valid), .ls_ready(ls_ready),
      .csr_valid(csr_valid), .csr_ready(csr_ready),
      .out_op(out_op), .out_pc(out_pc), .out_a(out_a), .out_b(out_b),
      .out_imm(out_imm), .out_rd(out_rd),
      .ls_idle(ls_idle), .flush(flush),
      .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
      .trap_ack(trap_ack), .fence_done(fence_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference: what the instruction should produce, straight from the decode rules.
   function automatic exp_t model(input logic [15:0] d, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] imm, input logic [4:0] rd);
      exp_t e;
      int unit;
      unit    = int'(d[15:14]);
      e.cause = 4'd0;
      if (d[1])           begin e.kind = 3; e.cause = 4'd2;  end
      else if (d[3])      begin e.kind = 3; e.cause = 4'd11; end
      else if (d[2])      begin e.kind = 3; e.cause = 4'd3;  end
      else if (d[4])      e.kind = 4;
      else if (d[5])      e.kind = 2;
      else if (unit == 0) e.kind = 0;
      else if (unit == 1) e.kind = 1;
      else                begin e.kind = 3; e.cause = 4'd2;  end
      e.op  = {d[14], d[13:11], d[10:7], d[6], d[0]};
      e.pc  = pc;
      e.a   = a;
      e.b   = b;
      e.imm = imm;
      e.rd  = rd;
      return e;
   endfunction

   // Monitor: pop the oldest expectation whenever the DUT completes an output event.
   always @(negedge clk) begin : monitor
      exp_t e;
      int   got;
      if (sb_en) begin
         got = -1;
         if (alu_valid | ls_valid | csr_valid)
            chk("one_valid", 32'($countones({alu_valid, ls_valid, csr_valid})), 32'd1);
         if (alu_valid && alu_ready)      got = 0;
         else if (ls_valid && ls_ready)   got = 1;
         else if (csr_valid && csr_ready) got = 2;
         else if (trap_valid && trap_ack) got = 3;
         else if (fence_done)             got = 4;
         if (got >= 0) begin
            if (sb.size() == 0) begin
               chk("sb_unexpected_event", 32'(got), 32'hFFFF_FFFF);
            end else begin
               e = sb.pop_front();
               chk("sb_kind", 32'(got), 32'(e.kind));
               if (got < 3) begin
                  chk("sb_op",  32'(out_op),  32'(e.op));
                  chk("sb_pc",  out_pc,  e.pc);
                  chk("sb_a",   out_a,   e.a);
                  chk("sb_b",   out_b,   e.b);
                  chk("sb_imm", out_imm, e.imm);
                  chk("sb_rd",  32'(out_rd),  32'(e.rd));
               end else if (got == 3) begin
                  chk("sb_cause",   32'(trap_cause), 32'(e.cause));
                  chk("sb_trap_pc", trap_pc, e.pc);
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [15:0] d, input logic [31:0] pc);
      in_valid  = v;
      in_decode = d;
      in_pc     = pc;
      in_rs1    = pc + 32'd1;
      in_rs2    = pc + 32'd2;
      in_imm    = pc + 32'd3;
      in_rd     = pc[6:2];
   endtask

   initial begin
      logic [15:0] d;
      rst_n = 1'b0;
      drive(1'b0, 16'h0, 32'h0);
      alu_ready = 1'b0; ls_ready = 1'b0; csr_ready = 1'b0;
      trap_ack = 1'b0; ls_idle = 1'b1; flush = 1'b0;

      // reset values
      #3;
      chk("rst_alu_valid",  32'(alu_valid), 32'd0);
      chk("rst_ls_valid",   32'(ls_valid),  32'd0);
      chk("rst_csr_valid",  32'(csr_valid), 32'd0);
      chk("rst_trap_valid", 32'(trap_valid), 32'd0);
      chk("rst_trap_cause", 32'(trap_cause), 32'd0);
      chk("rst_trap_pc",    trap_pc, 32'd0);
      chk("rst_fence_done", 32'(fence_done), 32'd0);
      chk("rst_out_op",     32'(out_op), 32'd0);
      chk("rst_out_pc",     out_pc, 32'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // back-to-back ADDs
      alu_ready = 1'b1;
      cyc(); drive(1'b1, 16'h1000, 32'h100);
      @(negedge clk); chk("add_in_ready", 32'(in_ready), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         cyc();
         if (i < 4) drive(1'b1, 16'h1000, 32'h100 + 32'(4 * i));
         else in_valid = 1'b0;
         @(negedge clk);
         chk("add_alu_valid", 32'(alu_valid), 32'd1);
         chk("add_out_pc",    out_pc, 32'h100 + 32'(4 * (i - 1)));
         chk("add_out_op",    32'(out_op), 32'h080);
         chk("add_out_a",     out_a, 32'h101 + 32'(4 * (i - 1)));
         chk("add_in_ready",  32'(in_ready), 32'd1);
      end
      cyc(); alu_ready = 1'b0;
      @(negedge clk); chk("add_done_valid", 32'(alu_valid), 32'd0);

      // LW stalled by ls_ready=0 for 3 cycles
      cyc(); drive(1'b1, 16'h4000, 32'h180);
      @(negedge clk);
      cyc(); drive(1'b1, 16'h1000, 32'h190);
      for (int j = 0; j < 4; j++) begin
         if (j == 3) begin ls_ready = 1'b1; in_valid = 1'b0; end
         @(negedge clk);
         chk("lw_ls_valid", 32'(ls_valid), 32'd1);
         chk("lw_out_pc",   out_pc, 32'h180);
         chk("lw_out_op",   32'(out_op), 32'h200);
         chk("lw_in_ready", 32'(in_ready), (j == 3) ? 32'd1 : 32'd0);
         cyc();
      end
      ls_ready = 1'b0;
      @(negedge clk);
      chk("lw_idle_valid", 32'(ls_valid), 32'd0);
      chk("lw_idle_ready", 32'(in_ready), 32'd1);

      // traps: illegal, ecall, ebreak
      for (int t = 0; t < 3; t++) begin
         logic [15:0] td;
         logic [3:0]  tc;
         logic [31:0] tpc;
         td  = (t == 0) ? 16'h0002 : (t == 1) ? 16'h0008 : 16'h0004;
         tc  = (t == 0) ? 4'd2 : (t == 1) ? 4'd11 : 4'd3;
         tpc = 32'h200 + 32'(t * 16);
         cyc(); drive(1'b1, td, tpc);
         @(negedge clk);
         cyc(); in_valid = 1'b0;
         for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("trap_valid",    32'(trap_valid), 32'd1);
            chk("trap_cause",    32'(trap_cause), 32'(tc));
            chk("trap_pc",       trap_pc, tpc);
            chk("trap_no_chan",  32'({alu_valid, ls_valid, csr_valid}), 32'd0);
            chk("trap_in_ready", 32'(in_ready), 32'd0);
            cyc();
         end
         trap_ack = 1'b1;
         @(negedge clk); chk("trap_ack_valid", 32'(trap_valid), 32'd1);
         cyc(); trap_ack = 1'b0;
         @(negedge clk);
         chk("trap_cleared",  32'(trap_valid), 32'd0);
         chk("trap_idle_rdy", 32'(in_ready), 32'd1);
      end

      // fence waiting on ls_idle
      ls_idle = 1'b0;
      cyc(); drive(1'b1, 16'h0010, 32'h300);
      @(negedge clk); chk("fence_accept", 32'(in_ready), 32'd1);
      cyc(); drive(1'b1, 16'h1000, 32'h310);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("fence_wait_rdy",  32'(in_ready), 32'd0);
         chk("fence_wait_done", 32'(fence_done), 32'd0);
         chk("fence_no_chan",   32'({alu_valid, ls_valid, csr_valid}), 32'd0);
         cyc();
      end
      ls_idle = 1'b1;
      @(negedge clk);
      chk("fence_done_pulse", 32'(fence_done), 32'd1);
      chk("fence_pulse_rdy",  32'(in_ready), 32'd0);
      cyc();
      @(negedge clk);
      chk("fence_done_once",  32'(fence_done), 32'd0);
      chk("fence_resume_rdy", 32'(in_ready), 32'd1);
      cyc(); in_valid = 1'b0; alu_ready = 1'b1;
      @(negedge clk);
      chk("fence_next_alu", 32'(alu_valid), 32'd1);
      chk("fence_next_pc",  out_pc, 32'h310);
      cyc(); alu_ready = 1'b0;

      // flush while CSR instruction is stalled
      cyc(); drive(1'b1, 16'h0020, 32'h400);
      @(negedge clk);
      cyc(); in_valid = 1'b0;
      @(negedge clk); chk("flush_csr_valid", 32'(csr_valid), 32'd1);
      cyc(); flush = 1'b1; drive(1'b1, 16'h1000, 32'h410);
      @(negedge clk); chk("flush_in_ready", 32'(in_ready), 32'd0);
      cyc(); flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_csr_cleared", 32'({alu_valid, ls_valid, csr_valid}), 32'd0);
      chk("flush_idle_rdy",    32'(in_ready), 32'd1);

      // asynchronous reset during TRAP
      cyc(); drive(1'b1, 16'h0002, 32'h500);
      @(negedge clk);
      cyc(); in_valid = 1'b0;
      @(negedge clk); chk("rtrap_valid", 32'(trap_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rtrap_async_valid", 32'(trap_valid), 32'd0);
      chk("rtrap_async_cause", 32'(trap_cause), 32'd0);
      chk("rtrap_async_pc",    trap_pc, 32'd0);
      chk("rtrap_async_op",    32'(out_op), 32'd0);
      chk("rtrap_async_opc",   out_pc, 32'd0);
      cyc(); cyc();
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk("rtrap_release_out", 32'({alu_valid, ls_valid, csr_valid, trap_valid, fence_done}), 32'd0);
         chk("rtrap_release_rdy", 32'(in_ready), 32'd1);
         cyc();
      end

      // randomized traffic against the scoreboard
      sb_en = 1'b1;
      for (int c = 0; c < 800; c++) begin
         alu_ready = ($urandom_range(0, 3) != 0);
         ls_ready  = ($urandom_range(0, 3) != 0);
         csr_ready = ($urandom_range(0, 3) != 0);
         trap_ack  = ($urandom_range(0, 2) == 0);
         ls_idle   = ($urandom_range(0, 2) != 0);
         d = 16'($urandom);
         if ($urandom_range(0, 9) < 7) d[5:1] = 5'd0;
         if ($urandom_range(0, 9) < 8) d[15] = 1'b0;
         in_valid  = ($urandom_range(0, 3) != 0);
         in_decode = d;
         in_pc     = $urandom;
         in_rs1    = $urandom;
         in_rs2    = $urandom;
         in_imm    = $urandom;
         in_rd     = 5'($urandom);
         @(negedge clk);
         if (in_valid && in_ready)
            sb.push_back(model(in_decode, in_pc, in_rs1, in_rs2, in_imm, in_rd));
         cyc();
      end

      // drain outstanding work with every consumer ready
      in_valid = 1'b0;
      alu_ready = 1'b1; ls_ready = 1'b1; csr_ready = 1'b1;
      trap_ack = 1'b1; ls_idle = 1'b1;
      for (int w = 0; w < 20 && sb.size() != 0; w++) cyc();
      chk("drain_sb_empty", 32'(sb.size()), 32'd0);
      cyc();
      @(negedge clk);
      chk("drain_idle_rdy", 32'(in_ready), 32'd1);
      sb_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
